// File: rtl/axi_read_only_ctrl_if.sv
// AXI4 read-channel and single-port memory signals of axi_read_only_ctrl.
// slave: the controller side; master: the AXI host, arbiter and memory side.
interface axi_read_only_ctrl_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_RDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH/8,
  parameter int MEM_ADDR_WIDTH     = 13
);
  logic [AXI4_ID_WIDTH-1:0]      ARID_i;
  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i;
  logic [7:0]                    ARLEN_i;
  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i;
  logic                          ARVALID_i;
  logic                          ARREADY_o;

  logic [AXI4_ID_WIDTH-1:0]      RID_o;
  logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o;
  logic [1:0]                    RRESP_o;
  logic                          RLAST_o;
  logic [AXI4_USER_WIDTH-1:0]    RUSER_o;
  logic                          RVALID_o;
  logic                          RREADY_i;

  logic                          MEM_CEN_o;
  logic                          MEM_WEN_o;
  logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o;
  logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o;
  logic [AXI_NUMBYTES-1:0]       MEM_BE_o;
  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i;
  logic                          grant_i;
  logic                          valid_o;

  modport slave (
    input  ARID_i, ARADDR_i, ARLEN_i, ARUSER_i, ARVALID_i, RREADY_i, MEM_Q_i, grant_i,
    output ARREADY_o, RID_o, RDATA_o, RRESP_o, RLAST_o, RUSER_o, RVALID_o,
    output MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o, valid_o
  );

  modport master (
    output ARID_i, ARADDR_i, ARLEN_i, ARUSER_i, ARVALID_i, RREADY_i, MEM_Q_i, grant_i,
    input  ARREADY_o, RID_o, RDATA_o, RRESP_o, RLAST_o, RUSER_o, RVALID_o,
    input  MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o, valid_o
  );
endinterface

// File: rtl/axi_read_only_ctrl.sv
// AXI4 read slave: one INCR full-width burst at a time mapped onto single-port
// memory reads, with a 2-entry R buffer absorbing RREADY back-pressure.
module axi_read_only_ctrl #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_RDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH/8,
  parameter int MEM_ADDR_WIDTH     = 13
) (
  input logic                 clk,
  input logic                 rst,
  axi_read_only_ctrl_if.slave bus
);
  localparam int OFFSET_BIT = $clog2(AXI4_RDATA_WIDTH) - 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [AXI4_ID_WIDTH-1:0]    arid_reg;
  logic [AXI4_USER_WIDTH-1:0]  aruser_reg;
  logic [MEM_ADDR_WIDTH-1:0]   araddr_reg;
  logic [7:0]                  arlen_reg;
  logic [8:0]                  req_cnt;
  logic [8:0]                  rsp_cnt;

  logic [AXI4_RDATA_WIDTH-1:0] fifo_mem [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  fifo_count;
  logic                        inflight;

  logic ar_hs, req_hs, r_hs, rvalid, rlast, room, req_last;
  logic arready, mem_valid;
  logic [2:0] occupancy;
  logic unused_araddr;

  // Low offset bits and bits above the memory range play no part in addressing.
  assign unused_araddr = ^{bus.ARADDR_i[AXI4_ADDRESS_WIDTH-1:MEM_ADDR_WIDTH+OFFSET_BIT],
                           bus.ARADDR_i[OFFSET_BIT-1:0]};

  assign rvalid   = (fifo_count != 2'd0);
  assign rlast    = rvalid & (rsp_cnt == {1'b0, arlen_reg});
  assign ar_hs    = arready & bus.ARVALID_i;
  assign r_hs     = rvalid & bus.RREADY_i;
  assign req_hs   = mem_valid & bus.grant_i;
  assign req_last = (req_cnt == {1'b0, arlen_reg});

  // Slots already committed (buffered + arriving next edge) minus the one leaving now.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, r_hs};
  assign room      = (occupancy < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ARVALID_i)       state_nxt = ISSUE;
      ISSUE:   if (req_hs && req_last)  state_nxt = DRAIN;
      DRAIN:   if (r_hs && rlast)       state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arready   = 1'b0;
    mem_valid = 1'b0;
    case (state)
      IDLE:    arready   = 1'b1;
      ISSUE:   mem_valid = room;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arid_reg    <= '0;
      aruser_reg  <= '0;
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= '0;
    end else begin
      if (ar_hs) begin
        arid_reg   <= bus.ARID_i;
        aruser_reg <= bus.ARUSER_i;
        araddr_reg <= bus.ARADDR_i[MEM_ADDR_WIDTH+OFFSET_BIT-1:OFFSET_BIT];
        arlen_reg  <= bus.ARLEN_i;
        req_cnt    <= '0;
        rsp_cnt    <= '0;
      end else begin
        if (req_hs) req_cnt <= req_cnt + 9'd1;
        if (r_hs)   rsp_cnt <= rsp_cnt + 9'd1;
      end

      inflight <= req_hs;

      if (inflight) begin
        fifo_mem[wr_ptr] <= bus.MEM_Q_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (r_hs) rd_ptr <= ~rd_ptr;

      case ({inflight, r_hs})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: ;
      endcase
    end
  end

  assign bus.ARREADY_o = arready;
  assign bus.valid_o   = mem_valid;
  assign bus.MEM_CEN_o = ~req_hs;
  assign bus.MEM_WEN_o = 1'b1;
  assign bus.MEM_A_o   = araddr_reg + MEM_ADDR_WIDTH'(req_cnt);
  assign bus.MEM_D_o   = '0;
  assign bus.MEM_BE_o  = {AXI_NUMBYTES{1'b1}};

  assign bus.RVALID_o = rvalid;
  assign bus.RLAST_o  = rlast;
  assign bus.RDATA_o  = fifo_mem[rd_ptr];
  assign bus.RID_o    = arid_reg;
  assign bus.RUSER_o  = aruser_reg;
  assign bus.RRESP_o  = 2'b00;
endmodule
